id_stage_decoder: RTL and testbench

Decode stage between fetch and the execute ALU in the RV64IM pipeline. It accepts a 32-bit instruction and its PC from fetch over a valid/ready handshake, and translates it into the team's 8-bit ALU instruction code with extracted operands. The results are held in a single-entry ID/EX pipeline register and presented to execute over a second valid/ready handshake. Branch mispredict and trap flushes from downstream are supported.

---
 rtl/id_stage_decoder.sv | 241 ++++++++++++++++++++++++
 tb/tb_id_stage_decoder.sv | 278 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/id_stage_decoder.sv
// rtl/id_stage_decoder.sv - RV64IM decode stage with single-entry ID/EX register
//
// Translates a 32-bit RV64IM instruction into an ALU instruction code plus
// extracted operands. The result is held in one pipeline register between a
// fetch-side and an execute-side valid/ready handshake.
//
// Optional feature: define DECODE_RV64M_EN to decode the M and word-M
//                   instructions; otherwise they are reported as illegal.
//
// Ports:
//   clk, rst_n        clock (rising edge), asynchronous active-low reset
//   in_valid/in_ready fetch handshake; in_instr/in_pc are the payload
//   flush             drops both the held and the incoming instruction
//   out_valid/out_ready execute handshake on the ID/EX register
//   out_code          ALU instruction code (0 when illegal)
//   out_rs1_idx/out_rs2_idx/out_rd_idx  fixed-position register indices
//   out_imm           sign-extended immediate (0 when illegal)
//   out_shamt         instr[25:20] zero-extended
//   out_pc            PC passed through
//   out_illegal       instruction could not be decoded
module id_stage_decoder #(
    parameter int XLEN   = 64,
    parameter int CODE_W = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [31:0]       in_instr,
    input  logic [XLEN-1:0]   in_pc,
    input  logic              flush,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [CODE_W-1:0] out_code,
    output logic [4:0]        out_rs1_idx,
    output logic [4:0]        out_rs2_idx,
    output logic [4:0]        out_rd_idx,
    output logic [XLEN-1:0]   out_imm,
    output logic [XLEN-1:0]   out_shamt,
    output logic [XLEN-1:0]   out_pc,
    output logic              out_illegal
);

    function automatic logic [CODE_W-1:0] cd(input int unsigned n);
        return CODE_W'(n);
    endfunction

    logic [6:0] opcode;
    logic [2:0] funct3;
    logic [6:0] funct7;
    logic [5:0] funct6;
    assign opcode = in_instr[6:0];
    assign funct3 = in_instr[14:12];
    assign funct7 = in_instr[31:25];
    assign funct6 = in_instr[31:26];

    logic [XLEN-1:0] imm_i, imm_s, imm_b, imm_j, imm_u;
    assign imm_i = {{(XLEN-12){in_instr[31]}}, in_instr[31:20]};
    assign imm_s = {{(XLEN-12){in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
    assign imm_b = {{(XLEN-13){in_instr[31]}}, in_instr[31], in_instr[7],
                    in_instr[30:25], in_instr[11:8], 1'b0};
    assign imm_j = {{(XLEN-21){in_instr[31]}}, in_instr[31], in_instr[19:12],
                    in_instr[20], in_instr[30:21], 1'b0};
    // U immediate stays unshifted; execute applies the <<12.
    assign imm_u = {{(XLEN-20){in_instr[31]}}, in_instr[31:12]};

    logic [CODE_W-1:0] dec_code;
    logic [XLEN-1:0]   dec_imm;
    logic              dec_illegal;

    always_comb begin
        dec_code    = '0;
        dec_imm     = '0;
        dec_illegal = 1'b0;
        case (opcode)
            7'b0110011: begin // OP
                if (funct7 == 7'b0000000) begin
                    case (funct3)
                        3'd0: dec_code = cd(0);
                        3'd1: dec_code = cd(5);
                        3'd2: dec_code = cd(8);
                        3'd3: dec_code = cd(9);
                        3'd4: dec_code = cd(2);
                        3'd5: dec_code = cd(6);
                        3'd6: dec_code = cd(3);
                        default: dec_code = cd(4);
                    endcase
                end else if (funct7 == 7'b0100000 && funct3 == 3'd0) begin
                    dec_code = cd(1);
                end else if (funct7 == 7'b0100000 && funct3 == 3'd5) begin
                    dec_code = cd(7);
`ifdef DECODE_RV64M_EN
                end else if (funct7 == 7'b0000001) begin
                    dec_code = cd(10 + 32'(funct3));
`endif
                end else begin
                    dec_illegal = 1'b1;
                end
            end
            7'b0010011: begin // OP-IMM
                dec_imm = imm_i;
                case (funct3)
                    3'd0: dec_code = cd(18);
                    3'd1: if (funct6 == 6'b000000) dec_code = cd(22);
                          else dec_illegal = 1'b1;
                    3'd2: dec_code = cd(25);
                    3'd3: dec_code = cd(26);
                    3'd4: dec_code = cd(19);
                    3'd5: if (funct6 == 6'b000000) dec_code = cd(23);
                          else if (funct6 == 6'b010000) dec_code = cd(24);
                          else dec_illegal = 1'b1;
                    3'd6: dec_code = cd(20);
                    default: dec_code = cd(21);
                endcase
            end
            7'b0011011: begin // OP-IMM-32, 5-bit shamt so funct7 must be exact
                dec_imm = imm_i;
                if (funct3 == 3'd0) dec_code = cd(29);
                else if (funct3 == 3'd1 && funct7 == 7'b0000000) dec_code = cd(30);
                else if (funct3 == 3'd5 && funct7 == 7'b0000000) dec_code = cd(31);
                else if (funct3 == 3'd5 && funct7 == 7'b0100000) dec_code = cd(32);
                else dec_illegal = 1'b1;
            end
            7'b0111011: begin // OP-32
                if (funct7 == 7'b0000000 && funct3 == 3'd0) dec_code = cd(33);
                else if (funct7 == 7'b0100000 && funct3 == 3'd0) dec_code = cd(34);
                else if (funct7 == 7'b0000000 && funct3 == 3'd1) dec_code = cd(35);
                else if (funct7 == 7'b0000000 && funct3 == 3'd5) dec_code = cd(36);
                else if (funct7 == 7'b0100000 && funct3 == 3'd5) dec_code = cd(37);
`ifdef DECODE_RV64M_EN
                else if (funct7 == 7'b0000001 && funct3 == 3'd0) dec_code = cd(38);
                else if (funct7 == 7'b0000001 && funct3 >= 3'd4) dec_code = cd(35 + 32'(funct3));
`endif
                else dec_illegal = 1'b1;
            end
            7'b0100011: begin // STORE
                dec_imm = imm_s;
                if (funct3 <= 3'd3) dec_code = cd(43 + 32'(funct3));
                else dec_illegal = 1'b1;
            end
            7'b0000011: begin // LOAD
                dec_imm = imm_i;
                case (funct3)
                    3'd0: dec_code = cd(59);
                    3'd1: dec_code = cd(60);
                    3'd2: dec_code = cd(61);
                    3'd3: dec_code = cd(65);
                    3'd4: dec_code = cd(62);
                    3'd5: dec_code = cd(63);
                    3'd6: dec_code = cd(64);
                    default: dec_illegal = 1'b1;
                endcase
            end
            7'b1100011: begin // BRANCH
                dec_imm = imm_b;
                case (funct3)
                    3'd0: dec_code = cd(47);
                    3'd1: dec_code = cd(48);
                    3'd4: dec_code = cd(49);
                    3'd5: dec_code = cd(50);
                    3'd6: dec_code = cd(51);
                    3'd7: dec_code = cd(52);
                    default: dec_illegal = 1'b1;
                endcase
            end
            7'b1101111: begin dec_code = cd(53); dec_imm = imm_j; end
            7'b1100111: begin
                dec_imm = imm_i;
                if (funct3 == 3'd0) dec_code = cd(54);
                else dec_illegal = 1'b1;
            end
            7'b0110111: begin dec_code = cd(55); dec_imm = imm_u; end
            7'b0010111: begin dec_code = cd(56); dec_imm = imm_u; end
            7'b1110011: begin // SYSTEM: only exact ECALL/EBREAK words
                if (in_instr == 32'h0000_0073) dec_code = cd(57);
                else if (in_instr == 32'h0010_0073) dec_code = cd(58);
                else dec_illegal = 1'b1;
            end
            default: dec_illegal = 1'b1;
        endcase
        if (dec_illegal) begin
            dec_code = '0;
            dec_imm  = '0;
        end
    end

    logic valid_q, valid_d;
    logic accept;

    assign in_ready = !valid_q || out_ready;
    assign accept   = in_valid && in_ready && !flush;

    always_comb begin
        valid_d = valid_q;
        if (flush)                      valid_d = 1'b0;
        else if (accept)                valid_d = 1'b1;
        else if (valid_q && out_ready)  valid_d = 1'b0;
    end

    logic [CODE_W-1:0] code_q;
    logic [4:0]        rs1_q, rs2_q, rd_q;
    logic [XLEN-1:0]   imm_q, shamt_q, pc_q;
    logic              illegal_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            code_q    <= '0;
            rs1_q     <= '0;
            rs2_q     <= '0;
            rd_q      <= '0;
            imm_q     <= '0;
            shamt_q   <= '0;
            pc_q      <= '0;
            illegal_q <= 1'b0;
        end else begin
            valid_q <= valid_d;
            if (accept) begin
                code_q    <= dec_code;
                rs1_q     <= in_instr[19:15];
                rs2_q     <= in_instr[24:20];
                rd_q      <= in_instr[11:7];
                imm_q     <= dec_imm;
                shamt_q   <= {{(XLEN-6){1'b0}}, in_instr[25:20]};
                pc_q      <= in_pc;
                illegal_q <= dec_illegal;
            end
        end
    end

    assign out_valid   = valid_q;
    assign out_code    = code_q;
    assign out_rs1_idx = rs1_q;
    assign out_rs2_idx = rs2_q;
    assign out_rd_idx  = rd_q;
    assign out_imm     = imm_q;
    assign out_shamt   = shamt_q;
    assign out_pc      = pc_q;
    assign out_illegal = illegal_q;

endmodule

// File: tb/tb_id_stage_decoder.sv
// tb/tb_id_stage_decoder.sv - self-checking bench for id_stage_decoder
module tb_id_stage_decoder;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid, in_ready, flush, out_valid, out_ready, out_illegal;
    logic [31:0] in_instr;
    logic [63:0] in_pc, out_imm, out_shamt, out_pc;
    logic [7:0]  out_code;
    logic [4:0]  out_rs1_idx, out_rs2_idx, out_rd_idx;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    id_stage_decoder #(.XLEN(64), .CODE_W(8)) dut (
        .clk(clk), .rst_n(rst_n),
        .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
        .flush(flush),
        .out_valid(out_valid), .out_ready(out_ready), .out_code(out_code),
        .out_rs1_idx(out_rs1_idx), .out_rs2_idx(out_rs2_idx), .out_rd_idx(out_rd_idx),
        .out_imm(out_imm), .out_shamt(out_shamt), .out_pc(out_pc), .out_illegal(out_illegal)
    );

    typedef struct {
        logic [7:0]  code;
        logic [4:0]  rs1, rs2, rd;
        logic [63:0] imm, shamt, pc;
        logic        illegal;
    } exp_t;

    localparam int F_N = 0, F_I = 1, F_S = 2, F_B = 3, F_J = 4, F_U = 5;
    localparam logic [31:0] M_R = 32'hFE00_707F, M_I = 32'h0000_707F;
    localparam logic [31:0] M_SH6 = 32'hFC00_707F, M_OP = 32'h0000_007F, M_ALL = 32'hFFFF_FFFF;

    // Encoding table: an instruction decodes to the first entry whose masked bits match.
    logic [31:0] tbl_mask[$];
    logic [31:0] tbl_match[$];
    int          tbl_code[$];
    int          tbl_fmt[$];
    exp_t        exp_q[$];

    function automatic logic [31:0] mk(input logic [6:0] f7, input logic [2:0] f3, input logic [6:0] opc);
        return {f7, 10'd0, f3, 5'd0, opc};
    endfunction

    function automatic void add(input logic [31:0] m, input logic [31:0] v, input int c, input int f);
        tbl_mask.push_back(m);
        tbl_match.push_back(v);
        tbl_code.push_back(c);
        tbl_fmt.push_back(f);
    endfunction

    function automatic void build_table();
        int ops_f3[10] = '{0, 0, 4, 6, 7, 1, 5, 5, 2, 3};
        int ops_f7[10] = '{0, 32, 0, 0, 0, 0, 0, 32, 0, 0};
        int ld_f3[7]   = '{0, 1, 2, 4, 5, 6, 3};
        int br_f3[6]   = '{0, 1, 4, 5, 6, 7};
        int oi_f3[6]   = '{0, 4, 6, 7, 2, 3};
        int oi_code[6] = '{18, 19, 20, 21, 25, 26};
        for (int k = 0; k < 10; k++) add(M_R, mk(7'(ops_f7[k]), 3'(ops_f3[k]), 7'h33), k, F_N);
`ifdef DECODE_RV64M_EN
        for (int k = 0; k < 8; k++) add(M_R, mk(7'd1, 3'(k), 7'h33), 10 + k, F_N);
        add(M_R, mk(7'd1, 3'd0, 7'h3B), 38, F_N);
        for (int k = 4; k < 8; k++) add(M_R, mk(7'd1, 3'(k), 7'h3B), 35 + k, F_N);
`endif
        for (int k = 0; k < 6; k++) add(M_I, mk(7'd0, 3'(oi_f3[k]), 7'h13), oi_code[k], F_I);
        add(M_SH6, mk(7'd0, 3'd1, 7'h13), 22, F_I);
        add(M_SH6, mk(7'd0, 3'd5, 7'h13), 23, F_I);
        add(M_SH6, mk(7'h20, 3'd5, 7'h13), 24, F_I);
        add(M_I, mk(7'd0, 3'd0, 7'h1B), 29, F_I);
        add(M_R, mk(7'd0, 3'd1, 7'h1B), 30, F_I);
        add(M_R, mk(7'd0, 3'd5, 7'h1B), 31, F_I);
        add(M_R, mk(7'h20, 3'd5, 7'h1B), 32, F_I);
        add(M_R, mk(7'd0, 3'd0, 7'h3B), 33, F_N);
        add(M_R, mk(7'h20, 3'd0, 7'h3B), 34, F_N);
        add(M_R, mk(7'd0, 3'd1, 7'h3B), 35, F_N);
        add(M_R, mk(7'd0, 3'd5, 7'h3B), 36, F_N);
        add(M_R, mk(7'h20, 3'd5, 7'h3B), 37, F_N);
        for (int k = 0; k < 4; k++) add(M_I, mk(7'd0, 3'(k), 7'h23), 43 + k, F_S);
        for (int k = 0; k < 7; k++) add(M_I, mk(7'd0, 3'(ld_f3[k]), 7'h03), 59 + k, F_I);
        for (int k = 0; k < 6; k++) add(M_I, mk(7'd0, 3'(br_f3[k]), 7'h63), 47 + k, F_B);
        add(M_OP, 32'h0000_006F, 53, F_J);
        add(M_I, 32'h0000_0067, 54, F_I);
        add(M_OP, 32'h0000_0037, 55, F_U);
        add(M_OP, 32'h0000_0017, 56, F_U);
        add(M_ALL, 32'h0000_0073, 57, F_N);
        add(M_ALL, 32'h0010_0073, 58, F_N);
    endfunction

    function automatic exp_t model(input logic [31:0] ins, input logic [63:0] pc);
        exp_t e;
        int hit = -1;
        logic [11:0] s12;
        logic [12:0] b13;
        logic [20:0] j21;
        logic [19:0] u20;
        for (int k = 0; k < tbl_mask.size(); k++)
            if (hit < 0 && (ins & tbl_mask[k]) == tbl_match[k]) hit = k;
        e.rs1 = ins[19:15];
        e.rs2 = ins[24:20];
        e.rd = ins[11:7];
        e.shamt = {58'd0, ins[25:20]};
        e.pc = pc;
        e.imm = 64'd0;
        e.code = 8'd0;
        e.illegal = (hit < 0);
        if (hit >= 0) begin
            e.code = 8'(tbl_code[hit]);
            s12 = ins[31:20];
            case (tbl_fmt[hit])
                F_I: e.imm = longint'($signed(s12));
                F_S: begin s12 = {ins[31:25], ins[11:7]}; e.imm = longint'($signed(s12)); end
                F_B: begin b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0}; e.imm = longint'($signed(b13)); end
                F_J: begin j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0}; e.imm = longint'($signed(j21)); end
                F_U: begin u20 = ins[31:12]; e.imm = longint'($signed(u20)); end
                default: e.imm = 64'd0;
            endcase
        end
        return e;
    endfunction

    function automatic logic [31:0] gen();
        int k;
        if ($urandom_range(0, 3) != 0) begin
            k = $urandom_range(0, tbl_mask.size() - 1);
            return tbl_match[k] | ($urandom & ~tbl_mask[k]);
        end
        return $urandom;
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock cycle: drive inputs, check outputs against the scoreboard head,
    // advance the reference, then move to 1 time unit after the next rising edge.
    task automatic step(input bit iv, input logic [31:0] ins, input logic [63:0] pc,
                        input bit ordy, input bit fl, output bit acc);
        bit have;
        in_valid = iv; in_instr = ins; in_pc = pc; out_ready = ordy; flush = fl;
        #1;
        have = (exp_q.size() != 0);
        chk("out_valid", 64'(out_valid), 64'(have));
        chk("in_ready", 64'(in_ready), 64'(!have || ordy));
        if (have) begin
            chk("code", 64'(out_code), 64'(exp_q[0].code));
            chk("rs1", 64'(out_rs1_idx), 64'(exp_q[0].rs1));
            chk("rs2", 64'(out_rs2_idx), 64'(exp_q[0].rs2));
            chk("rd", 64'(out_rd_idx), 64'(exp_q[0].rd));
            chk("imm", out_imm, exp_q[0].imm);
            chk("shamt", out_shamt, exp_q[0].shamt);
            chk("pc", out_pc, exp_q[0].pc);
            chk("illegal", 64'(out_illegal), 64'(exp_q[0].illegal));
        end
        acc = iv && (!have || ordy) && !fl;
        if (have && ordy) void'(exp_q.pop_front());
        if (fl) exp_q.delete();
        else if (acc) exp_q.push_back(model(ins, pc));
        @(posedge clk);
        #1;
    endtask

    initial begin
        bit acc;
        bit ordy;
        int idx;
        logic [31:0] cur;
        logic [63:0] cpc;
        logic [31:0] stream[4];

        build_table();
        rst_n = 1'b0; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_out_valid", 64'(out_valid), 64'd0);
        chk("rst_out_code", 64'(out_code), 64'd0);
        chk("rst_out_imm", out_imm, 64'd0);
        chk("rst_out_pc", out_pc, 64'd0);
        chk("rst_out_illegal", 64'(out_illegal), 64'd0);
        chk("rst_in_ready", 64'(in_ready), 64'd1);
        rst_n = 1'b1;

        // ADDI x1,x0,-1
        step(1, 32'hFFF0_0093, 64'h1000, 1, 0, acc);
        chk("addi_valid", 64'(out_valid), 64'd1);
        chk("addi_code", 64'(out_code), 64'd18);
        chk("addi_rd", 64'(out_rd_idx), 64'd1);
        chk("addi_rs1", 64'(out_rs1_idx), 64'd0);
        chk("addi_imm", out_imm, 64'hFFFF_FFFF_FFFF_FFFF);
        chk("addi_pc", out_pc, 64'h1000);

        // MUL x3,x1,x2
        step(1, 32'h0220_81B3, 64'h1004, 1, 0, acc);
        chk("mul_rs1", 64'(out_rs1_idx), 64'd1);
        chk("mul_rs2", 64'(out_rs2_idx), 64'd2);
        chk("mul_rd", 64'(out_rd_idx), 64'd3);
`ifdef DECODE_RV64M_EN
        chk("mul_code", 64'(out_code), 64'd10);
        chk("mul_illegal", 64'(out_illegal), 64'd0);
`else
        chk("mul_code", 64'(out_code), 64'd0);
        chk("mul_illegal", 64'(out_illegal), 64'd1);
`endif

        // SRAI x1,x1,63 then LUI x5,0x12345
        step(1, 32'h43F0_D093, 64'h1008, 1, 0, acc);
        chk("srai_code", 64'(out_code), 64'd24);
        chk("srai_shamt", out_shamt, 64'd63);
        step(1, 32'h1234_52B7, 64'h100C, 1, 0, acc);
        chk("lui_code", 64'(out_code), 64'd55);
        chk("lui_imm", out_imm, 64'h12345);
        step(0, 32'h0, 64'h0, 1, 0, acc);

        // Back-to-back stream with execute stalling in cycles 2 and 3
        stream = '{32'h0020_81B3, 32'h4020_81B3, 32'hFFF1_2083, 32'hFE20_8EE3};
        idx = 0;
        for (int c = 0; c < 20 && (idx < 4 || exp_q.size() != 0); c++) begin
            ordy = !(c == 2 || c == 3);
            step(idx < 4, (idx < 4) ? stream[idx] : 32'h0, 64'h2000 + 64'(idx * 4), ordy, 0, acc);
            if (acc) idx++;
        end
        chk("stream_sent", 64'(idx), 64'd4);
        chk("stream_drained", 64'(exp_q.size()), 64'd0);

        // Flush while a held instruction is present and another is offered
        step(1, 32'h0050_0113, 64'h3000, 0, 0, acc);
        step(1, 32'h0070_0193, 64'h3004, 1, 1, acc);
        chk("flush_valid", 64'(out_valid), 64'd0);
        step(0, 32'h0, 64'h0, 1, 0, acc);
        step(0, 32'h0, 64'h0, 1, 0, acc);

        // All-zero word is illegal but still flows
        step(1, 32'h0000_0000, 64'h4000, 1, 0, acc);
        chk("zero_illegal", 64'(out_illegal), 64'd1);
        chk("zero_valid", 64'(out_valid), 64'd1);
        chk("zero_code", 64'(out_code), 64'd0);
        step(0, 32'h0, 64'h0, 1, 0, acc);

        // Randomized traffic; fetch holds an offered word until it is taken or flushed
        cur = gen();
        cpc = {32'd0, $urandom} & ~64'd3;
        for (int n = 0; n < 600; n++) begin
            step($urandom_range(0, 3) != 0, cur, cpc,
                 $urandom_range(0, 3) != 0, $urandom_range(0, 19) == 0, acc);
            if (acc || flush) begin
                cur = gen();
                cpc = {$urandom, $urandom} & ~64'd3;
            end
        end
        step(0, 32'h0, 64'h0, 1, 0, acc);
        step(0, 32'h0, 64'h0, 1, 0, acc);

        // Asynchronous reset in the middle of a stall
        step(1, 32'h0030_81B3, 64'hABC0, 1, 0, acc);
        step(0, 32'h0, 64'h0, 0, 0, acc);
        chk("prereset_valid", 64'(out_valid), 64'd1);
        rst_n = 1'b0;
        #2;
        chk("async_rst_valid", 64'(out_valid), 64'd0);
        chk("async_rst_pc", out_pc, 64'd0);
        chk("async_rst_rd", 64'(out_rd_idx), 64'd0);
        exp_q.delete();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        step(0, 32'h0, 64'h0, 1, 0, acc);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
